cpu_pkt_mem: RTL
================

CPU_PKT_MEM -- requirements
Module: cpu_pkt_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the payload byte width.
REQ-002 SHALL have parameter RAM_DEPTH, default 128, the number of storage entries; power of two, minimum 4.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(RAM_DEPTH), the pointer width.
REQ-004 SHALL have port clk0 input 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst0_n input 1, the asynchronous active-low reset.
REQ-006 SHALL have ports wr_en, wr_last and wr_abort, each input 1: CPU byte write strobe, last-byte-of-packet mark, and packet abort.
REQ-007 SHALL have port wr_data input DATA_WIDTH, the CPU byte.
REQ-008 SHALL have port wr_ready output 1, high when free space is available.
REQ-009 SHALL have ports rd_valid output 1, rd_data output DATA_WIDTH and rd_last output 1, the frame-builder stream.
REQ-010 SHALL have port rd_ready input 1, the frame-builder accept.
REQ-011 SHALL have ports pkt_cnt output ADDR_WIDTH+1 (committed unread packets) and used_cnt output ADDR_WIDTH+1 (occupied entries, committed plus uncommitted).
REQ-012 SHALL have ports wr_ovf output 1 (sticky overflow flag) and ovf_clr input 1.

Function
REQ-013 SHALL store each byte with its wr_last bit in a RAM_DEPTH x (DATA_WIDTH+1) circular array, wrapping pointers modulo RAM_DEPTH.
REQ-014 SHALL accept a byte when wr_en && wr_ready, and set wr_ready = (used_cnt != RAM_DEPTH).
REQ-015 SHALL ignore wr_en while full, leave all state unchanged, and set wr_ovf; wr_ovf clears only on ovf_clr, with a set in the same cycle taking priority.
REQ-016 SHALL commit a packet on an accepted byte with wr_last=1, moving the commit pointer past that byte and incrementing pkt_cnt.
REQ-017 SHALL never present uncommitted bytes to the read port.
REQ-018 SHALL transfer a byte when rd_valid && rd_ready; rd_data and rd_last SHALL hold stable while rd_valid && !rd_ready.
REQ-019 SHALL, on a commit at rising edge N into an empty read side, assert rd_valid after edge N+2 with the packet's first byte.
REQ-020 SHALL sustain one transfer per cycle while committed data remains, using read-ahead prefetch with no bubbles between bytes or between packets.
REQ-021 SHALL decrement pkt_cnt on a transfer with rd_last=1; a simultaneous commit and last-byte transfer leaves pkt_cnt unchanged.
REQ-022 SHALL decrement used_cnt per transfer and increment it per accepted write; a simultaneous write and transfer leaves it unchanged.
REQ-023 SHALL allow a write into the entry freed by a same-cycle transfer when full.
REQ-024 SHALL drive rd_valid low when no committed byte is pending; rd_data is then don't-care.

Reset
REQ-025 SHALL, on rst0_n low, immediately clear all pointers, pkt_cnt, used_cnt, wr_ovf, rd_valid, rd_last and the prefetch state, and set wr_ready=1 and rd_data=0.
REQ-026 SHALL discard all stored and in-flight packets when reset is asserted mid-transfer; array contents need not be cleared.
REQ-027 SHALL treat reset deassertion as synchronous to clk0 and accept traffic from the first rising edge after release.

Configuration
REQ-028 SHALL, with CPU_PKT_MEM_ABORT_EN defined, rewind the write pointer to the commit pointer on wr_abort=1 and reduce used_cnt by the discarded uncommitted byte count.
REQ-029 SHALL, with CPU_PKT_MEM_ABORT_EN defined, give wr_abort priority over a same-cycle wr_en, so that byte is discarded and no commit occurs.
REQ-030 SHALL, without CPU_PKT_MEM_ABORT_EN, keep port wr_abort but ignore it, with uncommitted bytes remaining pending.

Verification
REQ-031 SHALL cover: reset, then write 3 bytes 0x11,0x22,0x33 with the last marked, rd_ready=1 -> rd_valid 2 cycles after commit, 0x11,0x22,0x33 on consecutive cycles, rd_last on 0x33 only, pkt_cnt 1->0.
REQ-032 SHALL cover: write 128 bytes with RAM_DEPTH=128 and no reads -> wr_ready low, used_cnt=128; an extra wr_en leaves state unchanged and sets wr_ovf=1; ovf_clr -> wr_ovf=0.
REQ-033 SHALL cover: full array, with a commit followed by a simultaneous write and transfer every cycle for 300 cycles -> no loss, data order preserved across pointer wrap.
REQ-034 SHALL cover: write 2 uncommitted bytes, then wr_abort (macro on) -> used_cnt back to 0, rd_valid stays low; next packet 0xA5 (last) read intact.
REQ-035 SHALL cover: rd_ready toggling 1,0,0,1 during a 4-byte packet -> rd_data held while stalled and no duplicated or skipped byte.
REQ-036 SHALL cover: rst0_n pulsed low mid-packet read -> outputs reach reset values asynchronously and pkt_cnt=0 after release.

Source files
------------

// File: rtl/cpu_pkt_mem.sv
// ============================================================================
// Module   : cpu_pkt_mem
// Purpose  : CPU-to-frame-builder packet buffer. The CPU writes bytes one at a
//            time; a packet becomes visible to the read port only once its
//            last byte is written. The read side streams committed bytes at
//            one per cycle through a two-entry read-ahead pipe.
// Options  : define CPU_PKT_MEM_ABORT_EN to let wr_abort discard the packet
//            currently being written (default build ignores wr_abort).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_pkt_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 128,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic                  wr_abort,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   pkt_cnt,
  output logic [ADDR_WIDTH:0]   used_cnt,
  output logic                  wr_ovf,
  input  logic                  ovf_clr
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  // Storage: each entry carries {last, data}
  logic [DATA_WIDTH:0] mem_q [RAM_DEPTH];

  // Write pointer, commit pointer (end of last complete packet), fetch pointer
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;

  // unc: bytes of the open packet; avail: committed bytes not yet fetched
  logic [ADDR_WIDTH:0] unc_q, unc_d;
  logic [ADDR_WIDTH:0] avail_q, avail_d;
  logic [ADDR_WIDTH:0] used_q, used_d;
  logic [ADDR_WIDTH:0] pkt_q, pkt_d;
  logic                ovf_q, ovf_d;

  // Read-ahead pipe: stage A holds the fetched entry, out is what the port shows
  logic                a_valid_q, a_valid_d;
  logic [DATA_WIDTH:0] a_q, a_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_WIDTH:0] out_q, out_d;

  logic abort_req;
  logic full;
  logic rd_fire;
  logic wr_acc;
  logic out_free;
  logic a_move;
  logic fetch;

`ifdef CPU_PKT_MEM_ABORT_EN
  assign abort_req = wr_abort;
`else
  // wr_abort is kept on the port but has no effect in this build
  logic unused_abort;
  assign unused_abort = wr_abort;
  assign abort_req    = 1'b0;
`endif

  assign full     = (used_q == FULL_CNT);
  assign rd_fire  = out_valid_q && rd_ready;
  // When full, the slot vacated by a same-cycle transfer may be reused
  assign wr_acc   = wr_en && !abort_req && (!full || rd_fire);
  assign out_free = !out_valid_q || rd_ready;
  assign a_move   = a_valid_q && out_free;
  assign fetch    = (avail_q != '0) && (!a_valid_q || a_move);

  // Storage write port; contents are never reset
  always_ff @(posedge clk0) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= {wr_last, wr_data};
    end
  end

  // Next-state for pointers, counters, overflow flag and read-ahead pipe
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    cmt_ptr_d   = cmt_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    unc_d       = unc_q;
    avail_d     = avail_q;
    used_d      = used_q;
    pkt_d       = pkt_q;
    ovf_d       = ovf_q;
    a_valid_d   = a_valid_q;
    a_d         = a_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;

    if (abort_req) begin
      wr_ptr_d = cmt_ptr_q;
      unc_d    = '0;
      used_d   = used_d - unc_q;
    end else if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      used_d   = used_d + CNT_ONE;
      if (wr_last) begin
        cmt_ptr_d = wr_ptr_q + PTR_ONE;
        unc_d     = '0;
        avail_d   = avail_d + unc_q + CNT_ONE;
        pkt_d     = pkt_d + CNT_ONE;
      end else begin
        unc_d = unc_q + CNT_ONE;
      end
    end

    if (rd_fire) begin
      used_d = used_d - CNT_ONE;
      if (out_q[DATA_WIDTH]) begin
        pkt_d = pkt_d - CNT_ONE;
      end
    end

    if (fetch) begin
      a_d       = mem_q[rd_ptr_q];
      a_valid_d = 1'b1;
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      avail_d   = avail_d - CNT_ONE;
    end else if (a_move) begin
      a_valid_d = 1'b0;
    end

    if (a_move) begin
      out_d       = a_q;
      out_valid_d = 1'b1;
    end else if (rd_fire) begin
      out_valid_d = 1'b0;
    end

    // A rejected write wins over a same-cycle clear
    if (wr_en && !abort_req && !wr_acc) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      wr_ptr_q    <= '0;
      cmt_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      unc_q       <= '0;
      avail_q     <= '0;
      used_q      <= '0;
      pkt_q       <= '0;
      ovf_q       <= 1'b0;
      a_valid_q   <= 1'b0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cmt_ptr_q   <= cmt_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      unc_q       <= unc_d;
      avail_q     <= avail_d;
      used_q      <= used_d;
      pkt_q       <= pkt_d;
      ovf_q       <= ovf_d;
      a_valid_q   <= a_valid_d;
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign wr_ready = !full;
  assign rd_valid = out_valid_q;
  assign rd_data  = out_q[DATA_WIDTH-1:0];
  assign rd_last  = out_q[DATA_WIDTH];
  assign pkt_cnt  = pkt_q;
  assign used_cnt = used_q;
  assign wr_ovf   = ovf_q;

endmodule

`default_nettype wire
